// File: rtl/lsu_ctrl_if.sv
// Data-memory port between the load/store unit and memory: a single req/ack
// transaction with byte strobes on writes and same-cycle read data on ack.
interface lsu_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns a LOAD/STORE issue into one data-memory req/ack
// transaction and returns an extended load value or an error report.
module lsu_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    lsu_ctrl_if.master        bus,
    output logic              done,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              err,
    output logic [1:0]        err_cause,
    output logic [31:0]       err_addr
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b11;

    // Counter value seen on the last permitted request cycle.
    localparam logic [7:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t      state, state_n;
    logic        is_load_q, is_load_n;
    logic [2:0]  funct3_q, funct3_n;
    logic [4:0]  rd_q, rd_n;
    logic [31:0] addr_q, addr_n;
    logic [7:0]  cnt_q, cnt_n;

    logic        issue_ready_q, issue_ready_n;
    logic        mem_req_q, mem_req_n;
    logic        mem_we_q, mem_we_n;
    logic [31:0] mem_addr_q, mem_addr_n;
    logic [31:0] mem_wdata_q, mem_wdata_n;
    logic [3:0]  mem_wstrb_q, mem_wstrb_n;
    logic        done_q, done_n;
    logic        wb_valid_q, wb_valid_n;
    logic [4:0]  wb_rd_q, wb_rd_n;
    logic [31:0] wb_data_q, wb_data_n;
    logic        err_q, err_n;
    logic [1:0]  err_cause_q, err_cause_n;
    logic [31:0] err_addr_q, err_addr_n;

    logic        is_load, is_store, mem_op;
    logic        illegal, misaligned;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;
    logic [31:0] shifted;
    logic [31:0] load_value;

    // Decode and legality of the instruction currently presented at issue.
    always_comb begin
        is_load    = (opcode == OP_LOAD);
        is_store   = (opcode == OP_STORE);
        mem_op     = is_load || is_store;
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (is_load) begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end else if (is_store) begin
            illegal = (funct3 >= 3'b011);
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Store lane placement: narrow data is replicated so any enabled lane sees it.
    always_comb begin
        lane_strb  = 4'b0000;
        lane_wdata = 32'h0000_0000;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    lane_strb  = 4'b0001 << addr[1:0];
                    lane_wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    lane_strb  = 4'b0011 << addr[1:0];
                    lane_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    lane_strb  = 4'b1111;
                    lane_wdata = store_data;
                end
            endcase
        end
    end

    // Load extraction from the returned word, using the captured byte offset.
    always_comb begin
        shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_value = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_value = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_value = {24'h000000, shifted[7:0]};
            3'b101:  load_value = {16'h0000, shifted[15:0]};
            default: load_value = shifted;
        endcase
    end

    // Next-state and next-output logic; every output is a register fed from here.
    always_comb begin
        state_n       = state;
        is_load_n     = is_load_q;
        funct3_n      = funct3_q;
        rd_n          = rd_q;
        addr_n        = addr_q;
        cnt_n         = cnt_q;
        issue_ready_n = issue_ready_q;
        mem_req_n     = mem_req_q;
        mem_we_n      = mem_we_q;
        mem_addr_n    = mem_addr_q;
        mem_wdata_n   = mem_wdata_q;
        mem_wstrb_n   = mem_wstrb_q;
        done_n        = done_q;
        wb_valid_n    = wb_valid_q;
        wb_rd_n       = wb_rd_q;
        wb_data_n     = wb_data_q;
        err_n         = err_q;
        err_cause_n   = err_cause_q;
        err_addr_n    = err_addr_q;

        case (state)
            IDLE: begin
                if (issue_valid && mem_op) begin
                    is_load_n     = is_load;
                    funct3_n      = funct3;
                    rd_n          = rd;
                    addr_n        = addr;
                    cnt_n         = 8'd0;
                    issue_ready_n = 1'b0;
                    if (illegal || misaligned) begin
                        state_n     = RESP;
                        done_n      = 1'b1;
                        err_n       = 1'b1;
                        err_cause_n = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
                        err_addr_n  = addr;
                    end else begin
                        state_n     = ACCESS;
                        mem_req_n   = 1'b1;
                        mem_we_n    = is_store;
                        mem_addr_n  = {addr[31:2], 2'b00};
                        mem_wdata_n = lane_wdata;
                        mem_wstrb_n = lane_strb;
                    end
                end
            end

            ACCESS: begin
                // An ack on the final permitted cycle still completes normally.
                if (bus.mem_ack) begin
                    state_n   = RESP;
                    mem_req_n = 1'b0;
                    done_n    = 1'b1;
                    if (is_load_q) begin
                        wb_valid_n = 1'b1;
                        wb_rd_n    = rd_q;
                        wb_data_n  = load_value;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT_LAST)) begin
                    state_n     = RESP;
                    mem_req_n   = 1'b0;
                    done_n      = 1'b1;
                    err_n       = 1'b1;
                    err_cause_n = CAUSE_TIMEOUT;
                    err_addr_n  = addr_q;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end

            RESP: begin
                state_n       = IDLE;
                issue_ready_n = 1'b1;
                done_n        = 1'b0;
                wb_valid_n    = 1'b0;
                wb_rd_n       = 5'd0;
                wb_data_n     = 32'h0000_0000;
                err_n         = 1'b0;
                err_cause_n   = 2'b00;
                err_addr_n    = 32'h0000_0000;
            end

            default: begin
                state_n       = IDLE;
                issue_ready_n = 1'b1;
                mem_req_n     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset also abandons any in-flight access silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            is_load_q     <= 1'b0;
            funct3_q      <= 3'b000;
            rd_q          <= 5'd0;
            addr_q        <= 32'h0000_0000;
            cnt_q         <= 8'd0;
            issue_ready_q <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0000_0000;
            mem_wdata_q   <= 32'h0000_0000;
            mem_wstrb_q   <= 4'b0000;
            done_q        <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= 32'h0000_0000;
            err_q         <= 1'b0;
            err_cause_q   <= 2'b00;
            err_addr_q    <= 32'h0000_0000;
        end else begin
            state         <= state_n;
            is_load_q     <= is_load_n;
            funct3_q      <= funct3_n;
            rd_q          <= rd_n;
            addr_q        <= addr_n;
            cnt_q         <= cnt_n;
            issue_ready_q <= issue_ready_n;
            mem_req_q     <= mem_req_n;
            mem_we_q      <= mem_we_n;
            mem_addr_q    <= mem_addr_n;
            mem_wdata_q   <= mem_wdata_n;
            mem_wstrb_q   <= mem_wstrb_n;
            done_q        <= done_n;
            wb_valid_q    <= wb_valid_n;
            wb_rd_q       <= wb_rd_n;
            wb_data_q     <= wb_data_n;
            err_q         <= err_n;
            err_cause_q   <= err_cause_n;
            err_addr_q    <= err_addr_n;
        end
    end

    assign issue_ready   = issue_ready_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign done          = done_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign err           = err_q;
    assign err_cause     = err_cause_q;
    assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a table of single-instruction vectors with hand-computed
// results, plus reset-abort and back-to-back issue sequences.
module tb_lsu_ctrl;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam int NEVER   = 255;
    localparam int NUM_VEC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        done;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;
    logic [1:0]  err_cause;
    logic [31:0] err_addr;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;
    int accept_q[$];

    lsu_ctrl_if bus ();

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .opcode      (opcode),
        .funct3      (funct3),
        .rd          (rd),
        .addr        (addr),
        .store_data  (store_data),
        .bus         (bus.master),
        .done        (done),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .err         (err),
        .err_cause   (err_cause),
        .err_addr    (err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle_cnt++;
        if (!rst && issue_valid && issue_ready && (opcode == OP_LOAD || opcode == OP_STORE))
            accept_q.push_back(cycle_cnt);
    end

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] sd;
        int          ack_delay;
        logic [31:0] rdata;
        logic        accepted;
        int          req_cycles;
        logic [31:0] m_addr;
        logic        m_we;
        logic [31:0] m_wdata;
        logic [3:0]  m_wstrb;
        logic        wbv;
        logic [31:0] wbd;
        logic        e;
        logic [1:0]  cause;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs [NUM_VEC];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        checkOutput($sformatf("v%0d ready before issue", idx), {31'd0, issue_ready}, 32'd1);
        issue_valid = 1'b1;
        opcode      = v.opcode;
        funct3      = v.funct3;
        rd          = v.rd;
        addr        = v.addr;
        store_data  = v.sd;
        @(negedge clk);
        issue_valid = 1'b0;
        if (!v.accepted) begin
            checkOutput($sformatf("v%0d ignored ready", idx), {31'd0, issue_ready}, 32'd1);
            checkOutput($sformatf("v%0d ignored req", idx), {31'd0, bus.mem_req}, 32'd0);
            checkOutput($sformatf("v%0d ignored done", idx), {31'd0, done}, 32'd0);
            return;
        end
        checkOutput($sformatf("v%0d ready busy", idx), {31'd0, issue_ready}, 32'd0);
        n = 0;
        while (bus.mem_req === 1'b1 && n < 300) begin
            n++;
            checkOutput($sformatf("v%0d mem_addr c%0d", idx, n), bus.mem_addr, v.m_addr);
            checkOutput($sformatf("v%0d mem_we c%0d", idx, n), {31'd0, bus.mem_we}, {31'd0, v.m_we});
            checkOutput($sformatf("v%0d mem_wstrb c%0d", idx, n), {28'd0, bus.mem_wstrb}, {28'd0, v.m_wstrb});
            if (v.m_we)
                checkOutput($sformatf("v%0d mem_wdata c%0d", idx, n), bus.mem_wdata, v.m_wdata);
            if (n - 1 == v.ack_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = v.rdata;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'h0BAD_F00D;
            end
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        checkOutput($sformatf("v%0d req cycles", idx), n, v.req_cycles);
        checkOutput($sformatf("v%0d resp done", idx), {31'd0, done}, 32'd1);
        checkOutput($sformatf("v%0d resp wb_valid", idx), {31'd0, wb_valid}, {31'd0, v.wbv});
        checkOutput($sformatf("v%0d resp wb_data", idx), wb_data, v.wbd);
        if (v.wbv)
            checkOutput($sformatf("v%0d resp wb_rd", idx), {27'd0, wb_rd}, {27'd0, v.rd});
        checkOutput($sformatf("v%0d resp err", idx), {31'd0, err}, {31'd0, v.e});
        checkOutput($sformatf("v%0d resp err_cause", idx), {30'd0, err_cause}, {30'd0, v.cause});
        if (v.e)
            checkOutput($sformatf("v%0d resp err_addr", idx), err_addr, v.eaddr);
        checkOutput($sformatf("v%0d resp ready", idx), {31'd0, issue_ready}, 32'd0);
        @(negedge clk);
        checkOutput($sformatf("v%0d post done", idx), {31'd0, done}, 32'd0);
        checkOutput($sformatf("v%0d post err", idx), {31'd0, err}, 32'd0);
        checkOutput($sformatf("v%0d post ready", idx), {31'd0, issue_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_cnt;
        int load_ok;
        int store_seen;
        int gap;

        //            op        f3      rd    addr          sd            dly   rdata         acc rq  m_addr        we  m_wdata       strb     wbv wbd           e  cause  eaddr
        vecs[0]  = '{OP_STORE, 3'b000, 5'd0, 32'h0000_1003, 32'hAABB_CCDD, 1,    32'h0,        1, 2, 32'h0000_1000, 1, 32'hDDDD_DDDD, 4'b1000, 0, 32'h0,        0, 2'b00, 32'h0};
        vecs[1]  = '{OP_LOAD,  3'b000, 5'd5, 32'h0000_2002, 32'h0,         0,    32'h12FF_3456, 1, 1, 32'h0000_2000, 0, 32'h0,        4'b0000, 1, 32'hFFFF_FFFF, 0, 2'b00, 32'h0};
        vecs[2]  = '{OP_LOAD,  3'b100, 5'd6, 32'h0000_2002, 32'h0,         0,    32'h12FF_3456, 1, 1, 32'h0000_2000, 0, 32'h0,        4'b0000, 1, 32'h0000_00FF, 0, 2'b00, 32'h0};
        vecs[3]  = '{OP_LOAD,  3'b001, 5'd7, 32'h0000_2002, 32'h0,         0,    32'h12FF_3456, 1, 1, 32'h0000_2000, 0, 32'h0,        4'b0000, 1, 32'h0000_12FF, 0, 2'b00, 32'h0};
        vecs[4]  = '{OP_LOAD,  3'b101, 5'd8, 32'h0000_2000, 32'h0,         0,    32'h1234_ABCD, 1, 1, 32'h0000_2000, 0, 32'h0,        4'b0000, 1, 32'h0000_ABCD, 0, 2'b00, 32'h0};
        vecs[5]  = '{OP_LOAD,  3'b001, 5'd9, 32'h0000_2000, 32'h0,         0,    32'h1234_ABCD, 1, 1, 32'h0000_2000, 0, 32'h0,        4'b0000, 1, 32'hFFFF_ABCD, 0, 2'b00, 32'h0};
        vecs[6]  = '{OP_LOAD,  3'b010, 5'd1, 32'h0000_3002, 32'h0,         NEVER, 32'h0,        1, 0, 32'h0,         0, 32'h0,        4'b0000, 0, 32'h0,        1, 2'b01, 32'h0000_3002};
        vecs[7]  = '{OP_LOAD,  3'b010, 5'd2, 32'h0000_0040, 32'h0,         NEVER, 32'h0,        1, 4, 32'h0000_0040, 0, 32'h0,        4'b0000, 0, 32'h0,        1, 2'b10, 32'h0000_0040};
        vecs[8]  = '{OP_STORE, 3'b001, 5'd0, 32'h0000_1002, 32'h0000_BEEF, 2,    32'h0,        1, 3, 32'h0000_1000, 1, 32'hBEEF_BEEF, 4'b1100, 0, 32'h0,        0, 2'b00, 32'h0};
        vecs[9]  = '{OP_STORE, 3'b010, 5'd0, 32'h0000_1004, 32'h0102_0304, 0,    32'h0,        1, 1, 32'h0000_1004, 1, 32'h0102_0304, 4'b1111, 0, 32'h0,        0, 2'b00, 32'h0};
        vecs[10] = '{OP_LOAD,  3'b011, 5'd4, 32'h0000_5001, 32'h0,         NEVER, 32'h0,        1, 0, 32'h0,         0, 32'h0,        4'b0000, 0, 32'h0,        1, 2'b11, 32'h0000_5001};
        vecs[11] = '{OP_STORE, 3'b100, 5'd0, 32'h0000_0010, 32'h1111_2222, NEVER, 32'h0,        1, 0, 32'h0,         0, 32'h0,        4'b0000, 0, 32'h0,        1, 2'b11, 32'h0000_0010};
        vecs[12] = '{OP_ALU,   3'b000, 5'd3, 32'h0000_0010, 32'h0,         NEVER, 32'h0,        0, 0, 32'h0,         0, 32'h0,        4'b0000, 0, 32'h0,        0, 2'b00, 32'h0};
        vecs[13] = '{OP_LOAD,  3'b010, 5'd0, 32'h0000_0080, 32'h0,         3,    32'hDEAD_BEEF, 1, 4, 32'h0000_0080, 0, 32'h0,        4'b0000, 1, 32'hDEAD_BEEF, 0, 2'b00, 32'h0};
        vecs[14] = '{OP_STORE, 3'b001, 5'd0, 32'h0000_1001, 32'h0000_1234, NEVER, 32'h0,        1, 0, 32'h0,         0, 32'h0,        4'b0000, 0, 32'h0,        1, 2'b01, 32'h0000_1001};
        vecs[15] = '{OP_LOAD,  3'b000, 5'd3, 32'h0000_2001, 32'h0,         0,    32'h0000_8000, 1, 1, 32'h0000_2000, 0, 32'h0,        4'b0000, 1, 32'hFFFF_FF80, 0, 2'b00, 32'h0};

        rst           = 1'b1;
        issue_valid   = 1'b0;
        opcode        = 7'd0;
        funct3        = 3'd0;
        rd            = 5'd0;
        addr          = 32'd0;
        store_data    = 32'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;

        repeat (3) @(negedge clk);
        checkOutput("reset issue_ready", {31'd0, issue_ready}, 32'd1);
        checkOutput("reset mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("reset mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
        checkOutput("reset mem_addr", bus.mem_addr, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("reset err", {31'd0, err}, 32'd0);
        checkOutput("reset wb_data", wb_data, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NUM_VEC; i++)
            applyStimulus(vecs[i], i);

        // Reset during the second request cycle of a word store.
        @(negedge clk);
        issue_valid = 1'b1;
        opcode      = OP_STORE;
        funct3      = 3'b010;
        rd          = 5'd0;
        addr        = 32'h0000_0200;
        store_data  = 32'h1234_5678;
        @(negedge clk);
        issue_valid = 1'b0;
        checkOutput("abort req c1", {31'd0, bus.mem_req}, 32'd1);
        @(negedge clk);
        checkOutput("abort req c2", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort req after rst", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("abort ready after rst", {31'd0, issue_ready}, 32'd1);
        checkOutput("abort done after rst", {31'd0, done}, 32'd0);
        checkOutput("abort err after rst", {31'd0, err}, 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checkOutput("late ack done", {31'd0, done}, 32'd0);
        checkOutput("late ack wb_valid", {31'd0, wb_valid}, 32'd0);
        checkOutput("late ack req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("late ack ready", {31'd0, issue_ready}, 32'd1);

        // Back-to-back lw then sw with issue_valid held and single-cycle acks.
        accept_q.delete();
        done_cnt   = 0;
        load_ok    = 0;
        store_seen = 0;
        @(negedge clk);
        issue_valid = 1'b1;
        opcode      = OP_LOAD;
        funct3      = 3'b010;
        rd          = 5'd7;
        addr        = 32'h0000_0100;
        store_data  = 32'h0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (accept_q.size() == 1 && opcode == OP_LOAD) begin
                opcode     = OP_STORE;
                funct3     = 3'b010;
                rd         = 5'd0;
                addr       = 32'h0000_0104;
                store_data = 32'h5566_7788;
            end
            if (accept_q.size() >= 2)
                issue_valid = 1'b0;
            if (done) begin
                done_cnt++;
                if (wb_valid && wb_rd == 5'd7 && wb_data == 32'hCAFE_BABE)
                    load_ok++;
            end
            if (bus.mem_req && bus.mem_we && bus.mem_addr == 32'h0000_0104 &&
                bus.mem_wdata == 32'h5566_7788 && bus.mem_wstrb == 4'b1111)
                store_seen = 1;
            bus.mem_ack   = bus.mem_req;
            bus.mem_rdata = 32'hCAFE_BABE;
        end
        bus.mem_ack = 1'b0;
        issue_valid = 1'b0;
        gap = (accept_q.size() >= 2) ? (accept_q[1] - accept_q[0]) : -1;
        checkOutput("b2b accept count", accept_q.size(), 32'd2);
        checkOutput("b2b accept spacing", gap, 32'd3);
        checkOutput("b2b done count", done_cnt, 32'd2);
        checkOutput("b2b load result", load_ok, 32'd1);
        checkOutput("b2b store data", store_seen, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
